rv32_bus_arbiter: RTL

RV32_BUS_ARBITER -- requirements
Module: rv32_bus_arbiter

---
 rtl/rv32_bus_pkg.sv | 31 +++
 rtl/rv32_bus_arbiter.sv | 110 +++++++++++
 2 files changed

// File: rtl/rv32_bus_pkg.sv
// Shared types for the rv32 bus arbiter: grant FSM states, grant ids and
// the request-arbitration rule used when the bus is free.
package rv32_bus_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    GRANT_INSTR = 2'd1,
    GRANT_DATA  = 2'd2
  } bus_state_t;

  localparam logic INSTR = 1'b0;
  localparam logic DATA  = 1'b1;

  // On a tie the master that was not served last wins, so neither side can starve.
  function automatic bus_state_t arbitrate(input logic instr_req,
                                           input logic data_req,
                                           input logic last_grant);
    bus_state_t next_state;
    if (instr_req && data_req) begin
      next_state = (last_grant == INSTR) ? GRANT_DATA : GRANT_INSTR;
    end else if (instr_req) begin
      next_state = GRANT_INSTR;
    end else if (data_req) begin
      next_state = GRANT_DATA;
    end else begin
      next_state = IDLE;
    end
    return next_state;
  endfunction

endpackage

// File: rtl/rv32_bus_arbiter.sv
// Two-master arbiter placing the rv32 instruction and data buses onto one
// single-port memory; the granted master's strobes pass straight through.
module rv32_bus_arbiter
  import rv32_bus_pkg::*;
(
  input  logic        clk,
  input  logic        reset,

  input  logic [31:0] instr_address_in,
  input  logic        instr_read_in,
  output logic [31:0] instr_read_value_out,
  output logic        instr_ready_out,

  input  logic [31:0] data_address_in,
  input  logic        data_read_in,
  input  logic        data_write_in,
  input  logic [3:0]  data_write_mask_in,
  input  logic [31:0] data_write_value_in,
  output logic [31:0] data_read_value_out,
  output logic        data_ready_out,

  output logic [31:0] mem_address_out,
  output logic        mem_read_out,
  output logic        mem_write_out,
  output logic [3:0]  mem_write_mask_out,
  output logic [31:0] mem_write_value_out,
  input  logic [31:0] mem_read_value_in,
  input  logic        mem_ready_in
);

  bus_state_t state_q, state_d;
  logic       last_grant_q, last_grant_d;
  logic       instr_req, data_req;

  assign instr_req = instr_read_in;
  assign data_req  = data_read_in | data_write_in;

  // A completed or abandoned grant hands the bus straight to a waiting peer;
  // only a completion is recorded in last_grant.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path through the case infers a latch.
    state_d      = state_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        state_d = arbitrate(instr_req, data_req, last_grant_q);
      end
      GRANT_INSTR: begin
        if (mem_ready_in) begin
          last_grant_d = INSTR;
          state_d      = data_req ? GRANT_DATA : IDLE;
        end else if (!instr_req) begin
          state_d = data_req ? GRANT_DATA : IDLE;
        end
      end
      GRANT_DATA: begin
        if (mem_ready_in) begin
          last_grant_d = DATA;
          state_d      = instr_req ? GRANT_INSTR : IDLE;
        end else if (!data_req) begin
          state_d = instr_req ? GRANT_INSTR : IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= INSTR;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Memory-side mux; address and data fields are don't-care while strobes are low.
  always_comb begin
    mem_address_out     = '0;
    mem_read_out        = 1'b0;
    mem_write_out       = 1'b0;
    mem_write_mask_out  = '0;
    mem_write_value_out = '0;
    case (state_q)
      GRANT_INSTR: begin
        mem_address_out = instr_address_in;
        mem_read_out    = instr_read_in;
      end
      GRANT_DATA: begin
        mem_address_out     = data_address_in;
        mem_read_out        = data_read_in;
        mem_write_out       = data_write_in;
        mem_write_mask_out  = data_write_mask_in;
        mem_write_value_out = data_write_value_in;
      end
      default: begin
      end
    endcase
  end

  assign instr_ready_out      = mem_ready_in && (state_q == GRANT_INSTR);
  assign data_ready_out       = mem_ready_in && (state_q == GRANT_DATA);
  assign instr_read_value_out = mem_read_value_in;
  assign data_read_value_out  = mem_read_value_in;

endmodule
